// File: rtl/token_client_pkg.sv
// token_client_pkg
//   Handshake and boolean codes shared with the tree-arbiter cells, plus a
//   small helper for decoding the arbiter's inverted boolean encoding.
//   No ports (package).
package token_client_pkg;

    // Handshake code driven on ur; the values match the arbiter cells.
    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_REQUEST = 2'd1,
        HS_LOCK    = 2'd2,
        HS_RELEASE = 2'd3
    } hs_code_t;

    // The arbiter network uses an inverted boolean: 0 means true.
    localparam logic BOOL_TRUE  = 1'b0;
    localparam logic BOOL_FALSE = 1'b1;

    // Decode a shared-encoding boolean into a plain active-high flag.
    function automatic logic isTrue(input logic b);
        return (b == BOOL_TRUE);
    endfunction

endpackage

// File: rtl/token_client_if.sv
// token_client_if
//   Bundles the job port (job_valid/job_len/job_ready), the arbiter
//   handshake (ur/ua) and the status flags of one token_client agent.
//   Modports:
//     master - the agent: drives ur, job_ready and status; samples job and ua
//     slave  - the environment: job source plus leaf arbiter cell
interface token_client_if #(
    parameter int LEN_W = 4
);
    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic [1:0]       ur;
    logic             ua;
    logic             busy;
    logic             done;
    logic             starve;
    logic             proto_err;

    modport master (
        input  job_valid, job_len, ua,
        output job_ready, ur, busy, done, starve, proto_err
    );

    modport slave (
        output job_valid, job_len, ua,
        input  job_ready, ur, busy, done, starve, proto_err
    );
endinterface

// File: rtl/token_client_sat_counter.sv
// token_client_sat_counter
//   Up-counter that stops at MAX instead of wrapping; clr has priority over inc.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     clr        - synchronous clear to zero
//     inc        - count up by one (holds at MAX)
//     count      - current value
module token_client_sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Saturating count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/token_client.sv
// token_client
//   Processor-side agent for the tree-arbiter handshake. Takes jobs of N
//   resource cycles, requests the resource from a leaf arbiter, holds it for
//   at most MAX_HOLD cycles per grant and re-requests for any remainder.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     bus        - token_client_if.master: job port, ur/ua handshake, and the
//                  busy / done / starve / proto_err status flags
module token_client
    import token_client_pkg::*;
#(
    parameter int LEN_W       = 4,
    parameter int MAX_HOLD    = 8,
    parameter int REQ_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    token_client_if.master bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int WAIT_W = $clog2(REQ_TIMEOUT + 1);

    hs_code_t          state;
    logic [LEN_W-1:0]  remaining;
    logic              busyR;
    logic              doneR;
    logic              starveR;
    logic              protoErrR;

    logic [HOLD_W-1:0] holdCnt;
    logic [WAIT_W-1:0] waitCnt;

    logic grant;
    logic jobReady;
    logic accept;
    logic holdClr;
    logic holdInc;
    logic waitClr;
    logic waitInc;
    logic lastLock;
    logic waitHit;

    assign grant    = isTrue(bus.ua);
    assign jobReady = (state == HS_IDLE) && (remaining == '0);
    assign accept   = bus.job_valid && jobReady;

    assign holdClr  = (state == HS_REQUEST) && grant;
    assign holdInc  = (state == HS_LOCK);
    // Cleared both on acceptance and when a (re-)request starts from IDLE.
    assign waitClr  = accept || ((state == HS_IDLE) && (remaining != '0));
    assign waitInc  = (state == HS_REQUEST) && !grant;

    // This LOCK cycle is the last one of the grant: either the job runs out
    // or the hold cap is reached (holdCnt counts LOCK cycles already done).
    assign lastLock = (remaining <= LEN_W'(1)) || (holdCnt == HOLD_W'(MAX_HOLD - 1));
    // The ungranted REQ cycle in progress brings wait_cnt to REQ_TIMEOUT.
    assign waitHit  = (waitCnt >= WAIT_W'(REQ_TIMEOUT - 1));

    token_client_sat_counter #(.MAX(MAX_HOLD), .W(HOLD_W)) uHoldCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (holdClr),
        .inc   (holdInc),
        .count (holdCnt)
    );

    token_client_sat_counter #(.MAX(REQ_TIMEOUT), .W(WAIT_W)) uWaitCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (waitClr),
        .inc   (waitInc),
        .count (waitCnt)
    );

    // Handshake FSM with its registered status outputs and job bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HS_IDLE;
            remaining <= '0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            starveR   <= 1'b0;
            protoErrR <= 1'b0;
        end else begin
            doneR <= 1'b0;
            // A grant is only meaningful while requesting.
            if (grant && (state != HS_REQUEST)) begin
                protoErrR <= 1'b1;
            end else begin
                protoErrR <= protoErrR;
            end

            case (state)
                HS_IDLE: begin
                    if (accept) begin
                        remaining <= bus.job_len;
                        starveR   <= 1'b0;
                        // A null job completes without touching the arbiter.
                        doneR     <= (bus.job_len == '0);
                    end else if (remaining != '0) begin
                        state <= HS_REQUEST;
                    end else begin
                        state <= HS_IDLE;
                    end
                end
                HS_REQUEST: begin
                    if (grant) begin
                        state <= HS_LOCK;
                        busyR <= 1'b1;
                    end else if (waitHit) begin
                        starveR <= 1'b1;
                    end else begin
                        starveR <= starveR;
                    end
                end
                HS_LOCK: begin
                    if (remaining != '0) begin
                        remaining <= remaining - LEN_W'(1);
                    end else begin
                        remaining <= remaining;
                    end
                    if (lastLock) begin
                        state <= HS_RELEASE;
                        busyR <= 1'b0;
                        doneR <= (remaining <= LEN_W'(1));
                    end else begin
                        state <= HS_LOCK;
                    end
                end
                HS_RELEASE: begin
                    state <= HS_IDLE;
                end
                default: begin
                    state <= HS_IDLE;
                    busyR <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ur        = state;
    assign bus.job_ready = jobReady;
    assign bus.busy      = busyR;
    assign bus.done      = doneR;
    assign bus.starve    = starveR;
    assign bus.proto_err = protoErrR;

endmodule

// File: tb/tb_token_client.sv
module tb_token_client;
    import token_client_pkg::*;

    localparam logic T = BOOL_TRUE;
    localparam logic F = BOOL_FALSE;
    localparam logic [1:0] I = 2'd0, Q = 2'd1, L = 2'd2, R = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nCmp = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    token_client_if #(.LEN_W(4)) bus ();

    token_client #(.LEN_W(4), .MAX_HOLD(8), .REQ_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic       v;
        logic [3:0] len;
        logic       ua;
        logic [1:0] ur;
        logic       b, d, s, r, p;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] len, input logic ua,
                       input logic [1:0] ur, input logic b, input logic d,
                       input logic s, input logic r, input logic p);
        vec_t e;
        e.v = v; e.len = len; e.ua = ua; e.ur = ur;
        e.b = b; e.d = d; e.s = s; e.r = r; e.p = p;
        vecs.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [6:0] want);
        logic [6:0] got;
        got = {bus.ur, bus.busy, bus.done, bus.starve, bus.job_ready, bus.proto_err};
        nCmp++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s: {ur,busy,done,starve,ready,perr} got %b want %b", name, got, want);
        end
    endtask

    // One cycle: check outputs of the current cycle, then present inputs for it.
    task automatic step(input string name, input logic v, input logic [3:0] len,
                        input logic ua, input logic [1:0] ur, input logic b,
                        input logic d, input logic s, input logic r, input logic p);
        @(negedge clk);
        cmp(name, {ur, b, d, s, r, p});
        bus.job_valid = v;
        bus.job_len   = len;
        bus.ua        = ua;
    endtask

    task automatic doReset(input string name);
        bus.job_valid = 1'b0;
        bus.job_len   = 4'd0;
        bus.ua        = F;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp(name, {I, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1;
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_len   = 4'd0;
        bus.ua        = F;

        // len 3, grant on the 2nd REQ cycle
        add(1, 3, F, I, 0, 0, 0, 1, 0);
        add(0, 0, F, I, 0, 0, 0, 0, 0);
        add(0, 0, F, Q, 0, 0, 0, 0, 0);
        add(0, 0, T, Q, 0, 0, 0, 0, 0);
        add(0, 0, F, L, 1, 0, 0, 0, 0);
        add(0, 0, F, L, 1, 0, 0, 0, 0);
        add(0, 0, F, L, 1, 0, 0, 0, 0);
        add(0, 0, F, R, 0, 1, 0, 0, 0);
        add(0, 0, F, I, 0, 0, 0, 1, 0);
        // len 11 split 8 + 3; an offer while not ready must be ignored
        add(1, 11, F, I, 0, 0, 0, 1, 0);
        add(1, 5, F, I, 0, 0, 0, 0, 0);
        add(0, 0, T, Q, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, F, L, 1, 0, 0, 0, 0);
        add(0, 0, F, R, 0, 0, 0, 0, 0);
        add(0, 0, F, I, 0, 0, 0, 0, 0);
        add(0, 0, T, Q, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, F, L, 1, 0, 0, 0, 0);
        add(0, 0, F, R, 0, 1, 0, 0, 0);
        add(0, 0, F, I, 0, 0, 0, 1, 0);
        // null job
        add(1, 0, F, I, 0, 0, 0, 1, 0);
        add(0, 0, F, I, 0, 1, 0, 1, 0);
        add(0, 0, F, I, 0, 0, 0, 1, 0);
        // grant while IDLE sets proto_err; later job unaffected
        add(0, 0, T, I, 0, 0, 0, 1, 0);
        add(0, 0, F, I, 0, 0, 0, 1, 1);
        add(1, 1, F, I, 0, 0, 0, 1, 1);
        add(0, 0, F, I, 0, 0, 0, 0, 1);
        add(0, 0, T, Q, 0, 0, 0, 0, 1);
        add(0, 0, T, L, 1, 0, 0, 0, 1);
        add(0, 0, F, R, 0, 1, 0, 0, 1);
        add(0, 0, F, I, 0, 0, 0, 1, 1);

        doReset("reset0");
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].v, vecs[i].len, vecs[i].ua,
                 vecs[i].ur, vecs[i].b, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].p);
        end

        // grant during LOCK alone sets proto_err
        doReset("reset1");
        step("plk0", 1, 1, F, I, 0, 0, 0, 1, 0);
        step("plk1", 0, 0, F, I, 0, 0, 0, 0, 0);
        step("plk2", 0, 0, T, Q, 0, 0, 0, 0, 0);
        step("plk3", 0, 0, T, L, 1, 0, 0, 0, 0);
        step("plk4", 0, 0, F, R, 0, 1, 0, 0, 1);
        step("plk5", 0, 0, F, I, 0, 0, 0, 1, 1);

        // starvation: 15 ungranted REQ cycles, starve visible from the 16th
        doReset("reset2");
        step("stv_acc", 1, 2, F, I, 0, 0, 0, 1, 0);
        step("stv_idle", 0, 0, F, I, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step($sformatf("stv_req%0d", k), 0, 0, F, Q, 0, 0, (k >= 16), 0, 0);
        end
        step("stv_req21", 0, 0, T, Q, 0, 0, 1, 0, 0);
        step("stv_lock1", 0, 0, F, L, 1, 0, 1, 0, 0);
        step("stv_lock2", 0, 0, F, L, 1, 0, 1, 0, 0);
        step("stv_rel", 0, 0, F, R, 0, 1, 1, 0, 0);
        step("stv_idle2", 1, 0, F, I, 0, 0, 1, 1, 0);
        step("stv_clear", 0, 0, F, I, 0, 1, 0, 1, 0);

        // reset asserted mid-LOCK with remaining = 5
        doReset("reset3");
        step("rl_acc", 1, 8, F, I, 0, 0, 0, 1, 0);
        step("rl_idle", 0, 0, F, I, 0, 0, 0, 0, 0);
        step("rl_req", 0, 0, T, Q, 0, 0, 0, 0, 0);
        step("rl_lock8", 0, 0, F, L, 1, 0, 0, 0, 0);
        step("rl_lock7", 0, 0, F, L, 1, 0, 0, 0, 0);
        step("rl_lock6", 0, 0, F, L, 1, 0, 0, 0, 0);
        step("rl_lock5", 0, 0, F, L, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 cmp("rl_async", {I, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        step("rl_post1", 0, 0, F, I, 0, 0, 0, 1, 0);
        step("rl_post2", 0, 0, F, I, 0, 0, 0, 1, 0);
        step("rl_post3", 0, 0, F, I, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
